// File: rtl/dcsk_chip_serializer.sv
// dcsk_chip_serializer
//   Differential chaos shift keying chip serializer. Each accepted data bit
//   produces one frame: SF reference chips taken straight from the chaos
//   stream, then SF modulated chips replaying the stored reference (inverted
//   when the data bit is 0). SF = 2^sf_log2, latched at frame start.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_sf_log2           log2 spreading factor, sampled at frame start
//   i_data_valid/i_data_bit/o_data_ready     data bit input stream
//   i_chaos_valid/i_chaos_bit/o_chaos_ready  chaos chip input stream
//   o_tx_valid/o_tx/i_tx_ready               chip output stream
//   o_tx_ref            chip belongs to the reference half
//   o_tx_last           last chip of the frame
//   o_chip_idx          chip index within the frame, 0..2*SF-1
//   o_busy              FSM is not idle (also exposes state for checkers)
//   o_sf_err            (DCSK_SER_SF_ERR_EN only) illegal sf_log2 refused
//
// Build option
//   DCSK_SER_SF_ERR_EN  defined: illegal i_sf_log2 at frame start is refused
//                       and flagged on o_sf_err. Undefined: it is clamped to
//                       1..SF_LOG2_MAX and the frame proceeds.
//
// Handshake rule for every stream: a transfer happens on a rising edge where
// valid and ready are both high; a source holds valid and payload stable
// until that transfer.
module dcsk_chip_serializer #(
  parameter int SF_LOG2_MAX = 4,
  parameter int SFW         = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [SFW-1:0]         i_sf_log2,
  input  logic                   i_data_valid,
  input  logic                   i_data_bit,
  output logic                   o_data_ready,
  input  logic                   i_chaos_valid,
  input  logic                   i_chaos_bit,
  output logic                   o_chaos_ready,
  output logic                   o_tx_valid,
  output logic                   o_tx,
  input  logic                   i_tx_ready,
  output logic                   o_tx_ref,
  output logic                   o_tx_last,
  output logic [SF_LOG2_MAX:0]   o_chip_idx,
  output logic                   o_busy
`ifdef DCSK_SER_SF_ERR_EN
  ,
  output logic                   o_sf_err
`endif
);

  localparam int CW = SF_LOG2_MAX;
  localparam int IW = SF_LOG2_MAX + 1;
  localparam logic [SFW-1:0] SF_MAX_W = SFW'(SF_LOG2_MAX);
  localparam logic [SFW-1:0] SF_ONE_W = SFW'(1);

  typedef enum logic [1:0] {S_IDLE, S_REF, S_MOD} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [SFW-1:0] sf_q;
  logic           bit_q;
  logic           ref_buf [2**SF_LOG2_MAX];

  logic [IW-1:0]  sf_val;
  logic           cnt_last;
  logic           adv;
  logic           mod_end;
  logic           start_ok;
  logic           frame_start;
  logic           chaos_take;

  function automatic logic [SFW-1:0] clamp_sf(input logic [SFW-1:0] s);
    if (s == '0)
      return SF_ONE_W;
    else if (s > SF_MAX_W)
      return SF_MAX_W;
    else
      return s;
  endfunction

`ifdef DCSK_SER_SF_ERR_EN
  assign start_ok = (i_sf_log2 != '0) && (i_sf_log2 <= SF_MAX_W);
`else
  assign start_ok = 1'b1;
`endif

  assign sf_val   = IW'(1) << sf_q;
  assign cnt_last = ({1'b0, cnt} == (sf_val - IW'(1)));

  // A new chip may be registered when the output slot is empty or is being
  // drained this cycle; otherwise the output must hold.
  assign adv = !o_tx_valid || i_tx_ready;

  // Final modulated chip: the next bit may start here, giving gapless frames.
  assign mod_end = (state == S_MOD) && adv && cnt_last;

  assign o_data_ready  = !i_rst && start_ok && ((state == S_IDLE) || mod_end);
  assign o_chaos_ready = !i_rst && (state == S_REF) && adv;
  assign o_busy        = (state != S_IDLE);

  assign frame_start = i_data_valid && o_data_ready;
  assign chaos_take  = i_chaos_valid && o_chaos_ready;

  // Reference chip store; contents are only read after being written in the
  // same frame, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (chaos_take)
      ref_buf[cnt] <= i_chaos_bit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sf_q       <= SF_ONE_W;
      bit_q      <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx       <= 1'b0;
      o_tx_ref   <= 1'b0;
      o_tx_last  <= 1'b0;
      o_chip_idx <= '0;
`ifdef DCSK_SER_SF_ERR_EN
      o_sf_err   <= 1'b0;
`endif
    end else begin
      // Drained slot empties unless a new chip is registered below.
      if (o_tx_valid && i_tx_ready)
        o_tx_valid <= 1'b0;

`ifdef DCSK_SER_SF_ERR_EN
      o_sf_err <= i_data_valid && !start_ok && ((state == S_IDLE) || mod_end);
`endif

      if (frame_start) begin
        bit_q <= i_data_bit;
        sf_q  <= clamp_sf(i_sf_log2);
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            cnt   <= '0;
            state <= S_REF;
          end
        end

        S_REF: begin
          if (chaos_take) begin
            o_tx_valid <= 1'b1;
            o_tx       <= i_chaos_bit;
            o_tx_ref   <= 1'b1;
            o_tx_last  <= 1'b0;
            o_chip_idx <= {1'b0, cnt};
            if (cnt_last) begin
              cnt   <= '0;
              state <= S_MOD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        S_MOD: begin
          if (adv) begin
            o_tx_valid <= 1'b1;
            o_tx       <= bit_q ? ref_buf[cnt] : ~ref_buf[cnt];
            o_tx_ref   <= 1'b0;
            o_tx_last  <= cnt_last;
            o_chip_idx <= sf_val + {1'b0, cnt};
            if (cnt_last) begin
              cnt   <= '0;
              state <= frame_start ? S_REF : S_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcsk_chip_serializer.sv
// Directed testbench for dcsk_chip_serializer (default parameters,
// SF_LOG2_MAX = 4). Expected chips are hand-computed and queued in exp_q as
// {last, ref, idx[4:0], tx}; every observed chip is popped against it.
module tb_dcsk_chip_serializer;

  localparam int SFM = 4;
  localparam int SFW = 4;
  localparam int IW  = SFM + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SFW-1:0] sf_log2 = '0;
  logic          data_valid = 1'b0;
  logic          data_bit = 1'b0;
  logic          data_ready;
  logic          chaos_valid = 1'b0;
  logic          chaos_bit = 1'b0;
  logic          chaos_ready;
  logic          tx_valid;
  logic          tx;
  logic          tx_ready = 1'b1;
  logic          tx_ref;
  logic          tx_last;
  logic [IW-1:0] chip_idx;
  logic          busy;
`ifdef DCSK_SER_SF_ERR_EN
  logic          sf_err;
`endif

  dcsk_chip_serializer #(.SF_LOG2_MAX(SFM), .SFW(SFW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sf_log2     (sf_log2),
    .i_data_valid  (data_valid),
    .i_data_bit    (data_bit),
    .o_data_ready  (data_ready),
    .i_chaos_valid (chaos_valid),
    .i_chaos_bit   (chaos_bit),
    .o_chaos_ready (chaos_ready),
    .o_tx_valid    (tx_valid),
    .o_tx          (tx),
    .i_tx_ready    (tx_ready),
    .o_tx_ref      (tx_ref),
    .o_tx_last     (tx_last),
    .o_chip_idx    (chip_idx),
    .o_busy        (busy)
`ifdef DCSK_SER_SF_ERR_EN
    ,
    .o_sf_err      (sf_err)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       chaos_q[$];
  logic       data_q[$];
  logic       chaos_stall = 1'b0;
  int         cyc = 0;
  int         chip_cyc[$];
  logic       track_busy = 1'b0;
  int         busy_low = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_chip(input logic t, input logic r, input logic l, input int idx);
    exp_q.push_back({l, r, IW'(idx), t});
  endtask

  task automatic drive();
    data_valid  = (data_q.size() != 0);
    data_bit    = (data_q.size() != 0) ? data_q[0] : 1'b0;
    chaos_valid = !chaos_stall && (chaos_q.size() != 0);
    chaos_bit   = (chaos_q.size() != 0) ? chaos_q[0] : 1'b0;
  endtask

  // One clock: sample at the falling edge, then update drivers after the
  // rising edge according to which handshakes completed.
  task automatic step();
    logic       dh;
    logic       ch;
    logic [7:0] cur;
    @(negedge clk);
    cur = {tx_last, tx_ref, chip_idx, tx};
    if (prev_hold)
      check("hold", cur, prev_out);
    prev_hold = tx_valid && !tx_ready;
    prev_out  = cur;
    if (track_busy && exp_q.size() > 1 && !busy)
      busy_low++;
    if (tx_valid && tx_ready) begin
      check("chip_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check("chip", cur, exp_q.pop_front());
      chip_cyc.push_back(cyc);
    end
    dh = data_valid && data_ready;
    ch = chaos_valid && chaos_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (dh) void'(data_q.pop_front());
    if (ch) void'(chaos_q.pop_front());
    drive();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic settle(input string tag);
    repeat (3) step();
    check(tag, {31'b0, busy}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    int  cs;
    int  tr;
    int  got;
    bit  cs_done;
    bit  tr_done;
    logic c8 [8];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_outs", {tx_last, tx_ref, chip_idx, tx}, 0);
    rst = 1'b0;
    #1;
    check("rst_data_ready", {31'b0, data_ready}, 1);
    check("rst_chaos_ready", {31'b0, chaos_ready}, 0);

    // SF=2, data 1, chaos 1,0
    sf_log2 = 4'd1;
    data_q = '{1'b1};
    chaos_q = '{1'b1, 1'b0};
    exp_chip(1, 1, 0, 0); exp_chip(0, 1, 0, 1);
    exp_chip(1, 0, 0, 2); exp_chip(0, 0, 1, 3);
    drive();
    run(30);
    settle("t1_idle");

    // SF=4, data 0, chaos 1,1,0,1; sf_log2 changes mid-frame without effect
    sf_log2 = 4'd2;
    data_q = '{1'b0};
    chaos_q = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_chip(1, 1, 0, 0); exp_chip(1, 1, 0, 1); exp_chip(0, 1, 0, 2); exp_chip(1, 1, 0, 3);
    exp_chip(0, 0, 0, 4); exp_chip(0, 0, 0, 5); exp_chip(1, 0, 0, 6); exp_chip(0, 0, 1, 7);
    drive();
    step();
    sf_log2 = 4'd1;
    run(40);
    settle("t2_idle");

    // Back-to-back bits 1,0 at SF=2, chaos 1,1,0,0
    sf_log2 = 4'd1;
    data_q = '{1'b1, 1'b0};
    chaos_q = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_chip(1, 1, 0, 0); exp_chip(1, 1, 0, 1); exp_chip(1, 0, 0, 2); exp_chip(1, 0, 1, 3);
    exp_chip(0, 1, 0, 0); exp_chip(0, 1, 0, 1); exp_chip(1, 0, 0, 2); exp_chip(1, 0, 1, 3);
    chip_cyc.delete();
    busy_low = 0;
    drive();
    step();
    track_busy = 1'b1;
    run(40);
    track_busy = 1'b0;
    check("t3_count", 32'(chip_cyc.size()), 8);
    if (chip_cyc.size() == 8)
      check("t3_contig", 32'(chip_cyc[7] - chip_cyc[0]), 7);
    check("t3_busy_low", 32'(busy_low), 0);
    settle("t3_idle");

    // SF=8 with a chaos underrun at chip 2 and a tx stall at chip 5
    sf_log2 = 4'd3;
    data_q = '{1'b1};
    c8 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) chaos_q.push_back(c8[i]);
    for (int i = 0; i < 8; i++) exp_chip(c8[i], 1, 0, i);
    for (int i = 0; i < 8; i++) exp_chip(c8[i], 0, (i == 7), 8 + i);
    cs_done = 0; tr_done = 0; cs = 0; tr = 0; n = 0;
    drive();
    while (exp_q.size() != 0 && n < 200) begin
      got = 16 - exp_q.size();
      if (!cs_done && got == 2) begin cs_done = 1; cs = 2; end
      chaos_stall = (cs > 0);
      if (cs > 0) cs--;
      if (!tr_done && got == 5) begin tr_done = 1; tr = 3; end
      tx_ready = !(tr > 0);
      if (tr > 0) tr--;
      step();
      n++;
    end
    chaos_stall = 1'b0;
    tx_ready = 1'b1;
    check("timeout", 32'(exp_q.size()), 0);
    settle("t4_idle");

    // Reset in the middle of an SF=4 frame, then a fresh SF=2 frame
    sf_log2 = 4'd2;
    data_q = '{1'b1};
    chaos_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_chip(1, 1, 0, 0); exp_chip(0, 1, 0, 1); exp_chip(1, 1, 0, 2); exp_chip(1, 1, 0, 3);
    drive();
    n = 0;
    while (exp_q.size() > 1 && n < 40) begin
      step();
      n++;
    end
    check("t5_pre", 32'(exp_q.size()), 1);
    rst = 1'b1;
    step();
    check("t5_rst_valid", {31'b0, tx_valid}, 0);
    check("t5_rst_busy", {31'b0, busy}, 0);
    exp_q.delete();
    chaos_q.delete();
    data_q.delete();
    rst = 1'b0;
    drive();
    #1;
    check("t5_data_ready", {31'b0, data_ready}, 1);
    sf_log2 = 4'd1;
    data_q = '{1'b1};
    chaos_q = '{1'b0, 1'b1};
    exp_chip(0, 1, 0, 0); exp_chip(1, 1, 0, 1); exp_chip(0, 0, 0, 2); exp_chip(1, 0, 1, 3);
    drive();
    run(30);
    settle("t5_idle");

    // sf_log2 = 0 at frame start
    sf_log2 = 4'd0;
`ifdef DCSK_SER_SF_ERR_EN
    data_q = '{1'b1};
    chaos_q = '{1'b1, 1'b1};
    drive();
    #1;
    check("t6_refuse_ready", {31'b0, data_ready}, 0);
    step();
    check("t6_sf_err", {31'b0, sf_err}, 1);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_bit_kept", 32'(data_q.size()), 1);
    data_q.delete();
    chaos_q.delete();
    drive();
    step();
    check("t6_sf_err_clear", {31'b0, sf_err}, 0);
    settle("t6_idle");
`else
    data_q = '{1'b1};
    chaos_q = '{1'b1, 1'b1};
    exp_chip(1, 1, 0, 0); exp_chip(1, 1, 0, 1); exp_chip(1, 0, 0, 2); exp_chip(1, 0, 1, 3);
    drive();
    run(30);
    settle("t6_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcsk_chip_serializer.md
DCSK_CHIP_SERIALIZER -- requirements
Module: dcsk_chip_serializer

Interface
REQ-001 Parameter SF_LOG2_MAX, default 4, largest supported log2 spreading factor; legal range 1..8.
REQ-002 Parameter SFW, default 4, width of i_sf_log2; SFW SHALL be at least clog2(SF_LOG2_MAX+1).
REQ-003 Port i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port i_rst  in  1  synchronous reset, active-high.
REQ-005 Port i_sf_log2  in  SFW  log2 of spreading factor SF, sampled at frame start.
REQ-006 Ports i_data_valid / i_data_bit / o_data_ready  in/in/out  1/1/1  data-bit stream, valid/ready.
REQ-007 Ports i_chaos_valid / i_chaos_bit / o_chaos_ready  in/in/out  1/1/1  chaos-chip stream, valid/ready.
REQ-008 Ports o_tx_valid / o_tx / i_tx_ready  out/out/in  1/1/1  transmitted-chip stream, valid/ready.
REQ-009 Port o_tx_ref  out  1  high while the o_tx chip belongs to the reference half.
REQ-010 Port o_tx_last  out  1  high on the last chip of a frame.
REQ-011 Port o_chip_idx  out  SF_LOG2_MAX+1  index of the o_tx chip within its frame, 0..2*SF-1.
REQ-012 Port o_busy  out  1  high when state is not IDLE.

Function
REQ-013 One frame carries one data bit: SF reference chips followed by SF modulated chips.
- SF = 2^sf_log2.
REQ-014 FSM states are IDLE, REF and MOD.
REQ-015 IDLE: o_data_ready = 1. On an i_data_valid handshake, the block SHALL:
- latch i_data_bit and the effective sf_log2;
- clear the chip counter;
- move to REF.
REQ-016 Chip advance is defined as adv = !o_tx_valid || i_tx_ready.
REQ-017 REF: o_chaos_ready = adv.
- Each chaos handshake stores the chip in ref_buf[cnt] and registers it onto o_tx with o_tx_ref = 1.
- Each chaos handshake increments cnt.
REQ-018 REF to MOD transition: on the handshake with cnt = SF-1; cnt then wraps to 0.
REQ-019 MOD: no chaos is consumed. Each cycle with adv = 1:
- o_tx is registered as ref_buf[cnt] when the latched bit is 1, and as ~ref_buf[cnt] when it is 0;
- o_tx_ref = 0;
- cnt increments.
REQ-020 On the MOD chip with cnt = SF-1, o_tx_last is set.
- If i_data_valid is high in that same cycle, the next bit is accepted (o_data_ready = 1 in that cycle only) and the block enters REF with no idle chip.
- Otherwise the block enters IDLE.
REQ-021 o_data_ready SHALL be 0 in REF and in MOD, except in the cycle defined in REQ-020.
REQ-022 Latency: a chip accepted or generated in cycle N appears on o_tx in cycle N+1.
REQ-023 o_chip_idx = cnt for REF chips and SF+cnt for MOD chips, registered alongside o_tx.
REQ-024 While o_tx_valid = 1 and i_tx_ready = 0, all of the following SHALL hold stable: o_tx, o_tx_ref, o_tx_last and o_chip_idx.
REQ-025 o_tx_valid clears when a chip is taken (i_tx_ready = 1) and no new chip is produced that cycle.
- In REF this covers a chaos underrun, where i_chaos_valid = 0.
- REF underrun stalls the frame; it does not skip chips.
REQ-026 A change of i_sf_log2 mid-frame SHALL have no effect until the next frame start.
REQ-027 ref_buf SHALL hold 2^SF_LOG2_MAX bits and requires no reset.

Reset
REQ-028 When i_rst = 1, regardless of state, the following SHALL apply at the next edge:
- state = IDLE;
- cnt = 0;
- the outputs o_tx_valid, o_tx, o_tx_ref, o_tx_last, o_chip_idx and o_busy = 0;
- o_data_ready = 1 once reset is released.
REQ-029 Reset mid-frame SHALL abort the frame; no partial frame resumes after reset.

Configuration
REQ-030 Macro DCSK_SER_SF_ERR_EN defined:
- adds output port o_sf_err (1 bit);
- a frame start with i_sf_log2 = 0 or > SF_LOG2_MAX is refused: the data bit is not consumed, o_data_ready = 0 that cycle, and o_sf_err pulses for one cycle.
REQ-031 Macro DCSK_SER_SF_ERR_EN undefined:
- o_sf_err is absent;
- illegal i_sf_log2 is clamped (0 to 1, > SF_LOG2_MAX to SF_LOG2_MAX) and the frame proceeds.

Verification
REQ-032 SF=2, data=1, chaos 1,0, tx_ready=1 -> o_tx 1,0,1,0; o_tx_ref 1,1,0,0; o_tx_last only on the 4th chip; o_chip_idx 0..3.
REQ-033 SF=4, data=0, chaos 1,1,0,1 -> o_tx 1,1,0,1,0,0,1,0.
REQ-034 Two bits (1 then 0) valid back-to-back, SF=2, chaos 1,1,0,0 -> 8 contiguous chips 1,1,1,1,0,0,1,1.
- No bubble between frames.
- o_busy stays high throughout.
REQ-035 SF=8, tx_ready low for 3 cycles at chip 5, and chaos_valid low for 2 cycles at chip 2:
- o_tx is held stable during each stall;
- there is no chip loss or duplication;
- the frame completes with 16 chips.
REQ-036 i_rst asserted at chip 3 of an SF=4 frame -> next cycle o_tx_valid=0, o_busy=0; the next frame restarts at o_chip_idx=0.
REQ-037 i_sf_log2=0 presented at frame start:
- with DCSK_SER_SF_ERR_EN -> o_sf_err pulses and no chip is emitted;
- without it -> a 4-chip SF=2 frame is emitted.
